edabk_pipe_cpu: RTL and testbench

- 32-bit RV32I-subset CPU core with a classic 5-stage in-order pipeline: IF, ID, EX, MEM, WB.
- Fetches from an external combinational instruction memory and accesses an external byte-enabled data memory.
- Top-level core of the EDABK CPU; system integration instantiates it next to IMEM/DMEM models.

---
 rtl/edabk_pipe_cpu.sv | 225 ++++++++++++++++++++++
 tb/tb_edabk_pipe_cpu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/edabk_pipe_cpu.sv
// EDABK 5-stage RV32I-subset core: IF/ID/EX/MEM/WB with
// EX/MEM + MEM/WB forwarding, load-use stall, branches resolved in EX.
package edabk_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc, a, b, imm;
    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic alt;
  } id_ex_t;

  typedef struct packed {
    logic we, ld, st;
    logic [4:0] rd;
    logic [2:0] f3;
    logic [31:0] res, sd;
  } ex_mem_t;

  typedef struct packed {
    logic we;
    logic [4:0] rd;
    logic [31:0] res;
  } mem_wb_t;
endpackage

module edabk_pipe_cpu
  import edabk_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  boot_add,
  output logic [DATA_WIDTH-1:0] A_IMEM,
  input  logic [DATA_WIDTH-1:0] Instr_in,
  output logic                  RD,
  output logic                  WR,
  output logic [DATA_WIDTH-1:0] A_DMEM,
  output logic [DATA_WIDTH-1:0] D_out,
  input  logic [DATA_WIDTH-1:0] D_in,
  output logic [3:0]            byte_mark,
  output logic                  DMEM_rst
);
  localparam id_ex_t ID_NOP = '{op: OP_IMM, default: '0};

  if_id_t ifid;
  id_ex_t idex, id_nx;
  ex_mem_t exmem, ex_nx;
  mem_wb_t memwb, mem_nx;
  logic [31:0] rf [32];
  logic [31:0] pc, imm, rv1, rv2;
  logic [31:0] fa, fb, op2, alu, sra, res, target;
  logic [31:0] sh, ldata, wdata;
  logic [6:0] op;
  logic [4:0] rs1, rs2;
  logic [3:0] mask;
  logic use1, use2, ld_use, cond, taken, writes;

  assign A_IMEM = pc;
  assign DMEM_rst = rst_n;

  assign op = ifid.ir[6:0];
  assign rs1 = ifid.ir[19:15];
  assign rs2 = ifid.ir[24:20];

  always_comb begin
    imm = {{20{ifid.ir[31]}}, ifid.ir[31:20]};
    unique case (1'b1)
      op == OP_ST:
        imm = {{20{ifid.ir[31]}}, ifid.ir[31:25], ifid.ir[11:7]};
      op == OP_BR:
        imm = {{19{ifid.ir[31]}}, ifid.ir[31], ifid.ir[7],
               ifid.ir[30:25], ifid.ir[11:8], 1'b0};
      op == OP_LUI || op == OP_AUI:
        imm = {ifid.ir[31:12], 12'd0};
      op == OP_JAL:
        imm = {{11{ifid.ir[31]}}, ifid.ir[31], ifid.ir[19:12],
               ifid.ir[20], ifid.ir[30:21], 1'b0};
      default: ;
    endcase
  end

  // WB write in the same cycle is visible to the ID read
  assign rv1 = (rs1 == 5'd0) ? '0 :
               (memwb.we && memwb.rd == rs1) ? memwb.res : rf[rs1];
  assign rv2 = (rs2 == 5'd0) ? '0 :
               (memwb.we && memwb.rd == rs2) ? memwb.res : rf[rs2];

  assign use1 = !(op inside {OP_LUI, OP_AUI, OP_JAL});
  assign use2 = op inside {OP_BR, OP_ST, OP_REG};
  assign ld_use = (idex.op == OP_LD) && (idex.rd != 5'd0) &&
                  ((use1 && rs1 == idex.rd) || (use2 && rs2 == idex.rd));

  assign id_nx = '{pc: ifid.pc, a: rv1, b: rv2, imm: imm, op: op,
                   rd: ifid.ir[11:7], rs1: rs1, rs2: rs2,
                   f3: ifid.ir[14:12], alt: ifid.ir[30]};

  always_comb begin
    fa = idex.a;
    fb = idex.b;
    if (memwb.we && memwb.rd == idex.rs1) fa = memwb.res;
    if (memwb.we && memwb.rd == idex.rs2) fb = memwb.res;
    if (exmem.we && !exmem.ld && exmem.rd == idex.rs1) fa = exmem.res;
    if (exmem.we && !exmem.ld && exmem.rd == idex.rs2) fb = exmem.res;
  end

  assign op2 = (idex.op == OP_REG || idex.op == OP_BR) ? fb : idex.imm;
  assign sra = $signed(fa) >>> op2[4:0];

  always_comb begin
    unique case (idex.f3)
      3'b000: alu = (idex.op == OP_REG && idex.alt) ? fa - op2 : fa + op2;
      3'b001: alu = fa << op2[4:0];
      3'b010: alu = {31'd0, $signed(fa) < $signed(op2)};
      3'b011: alu = {31'd0, fa < op2};
      3'b100: alu = fa ^ op2;
      3'b101: alu = idex.alt ? sra : fa >> op2[4:0];
      3'b110: alu = fa | op2;
      default: alu = fa & op2;
    endcase
    unique case (1'b1)
      idex.op == OP_LUI: res = idex.imm;
      idex.op == OP_AUI: res = idex.pc + idex.imm;
      idex.op inside {OP_JAL, OP_JALR}: res = idex.pc + 32'd4;
      idex.op inside {OP_LD, OP_ST}: res = fa + idex.imm;
      default: res = alu;
    endcase
    unique case (idex.f3)
      3'b000: cond = fa == fb;
      3'b001: cond = fa != fb;
      3'b100: cond = $signed(fa) < $signed(fb);
      3'b101: cond = $signed(fa) >= $signed(fb);
      3'b110: cond = fa < fb;
      3'b111: cond = fa >= fb;
      default: cond = 1'b0;
    endcase
  end

  assign taken = (idex.op == OP_BR && cond) ||
                 idex.op == OP_JAL || idex.op == OP_JALR;
  assign target = (idex.op == OP_JALR) ? (fa + idex.imm) & ~32'd1
                                       : idex.pc + idex.imm;
  assign writes = idex.op inside {OP_LUI, OP_AUI, OP_JAL, OP_JALR,
                                  OP_LD, OP_IMM, OP_REG};
  assign ex_nx = '{we: writes && idex.rd != 5'd0,
                   ld: idex.op == OP_LD, st: idex.op == OP_ST,
                   rd: idex.rd, f3: idex.f3, res: res, sd: fb};

  assign sh = D_in >> {exmem.res[1:0], 3'b000};

  always_comb begin
    unique case (exmem.f3)
      3'b000: ldata = {{24{sh[7]}}, sh[7:0]};
      3'b001: ldata = {{16{sh[15]}}, sh[15:0]};
      3'b100: ldata = {24'd0, sh[7:0]};
      3'b101: ldata = {16'd0, sh[15:0]};
      default: ldata = D_in;
    endcase
    unique case (exmem.f3[1:0])
      2'b00: begin
        mask = 4'b0001 << exmem.res[1:0];
        wdata = {4{exmem.sd[7:0]}};
      end
      2'b01: begin
        mask = 4'b0011 << {exmem.res[1], 1'b0};
        wdata = {2{exmem.sd[15:0]}};
      end
      default: begin
        mask = 4'b1111;
        wdata = exmem.sd;
      end
    endcase
  end

  assign RD = exmem.ld;
  assign WR = exmem.st;
  assign A_DMEM = exmem.res;
  assign byte_mark = (exmem.ld || exmem.st) ? mask : 4'd0;
  assign D_out = exmem.st ? wdata : '0;
  assign mem_nx = '{we: exmem.we, rd: exmem.rd,
                    res: exmem.ld ? ldata : exmem.res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= boot_add ? BOOT_ADDR : '0;
      ifid <= '{pc: '0, ir: NOP};
      idex <= ID_NOP;
      exmem <= '0;
      memwb <= '0;
    end else begin
      if (taken) pc <= target;
      else if (!ld_use) pc <= pc + 32'd4;
      if (taken) ifid <= '{pc: '0, ir: NOP};
      else if (!ld_use) ifid <= '{pc: pc, ir: Instr_in};
      idex <= (taken || ld_use) ? ID_NOP : id_nx;
      exmem <= ex_nx;
      memwb <= mem_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (memwb.we) begin
      rf[memwb.rd] <= memwb.res;
    end
  end
endmodule

// File: tb/tb_edabk_pipe_cpu.sv
// Directed bench for edabk_pipe_cpu with behavioural IMEM/DMEM.
// Each task loads a small program and checks fetch trace and memory.
module tb_edabk_pipe_cpu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic boot_add = 1'b0;
  logic [31:0] A_IMEM, Instr_in, A_DMEM, D_out, D_in;
  logic RD, WR, DMEM_rst;
  logic [3:0] byte_mark;
  logic [31:0] imem [256];
  logic [31:0] dmem [64];
  int checks = 0;
  int errors = 0;

  edabk_pipe_cpu #(.DATA_WIDTH(32), .BOOT_ADDR(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .boot_add(boot_add),
    .A_IMEM(A_IMEM), .Instr_in(Instr_in),
    .RD(RD), .WR(WR), .A_DMEM(A_DMEM), .D_out(D_out), .D_in(D_in),
    .byte_mark(byte_mark), .DMEM_rst(DMEM_rst)
  );

  always #5 clk = ~clk;

  assign Instr_in = imem[A_IMEM[9:2]];
  assign D_in = dmem[A_DMEM[7:2]];

  always @(posedge clk) begin
    if (WR) begin
      for (int b = 0; b < 4; b++)
        if (byte_mark[b]) dmem[A_DMEM[7:2]][8*b +: 8] <= D_out[8*b +: 8];
    end
  end

  function automatic logic [31:0] addi(input logic [4:0] rd,
      input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'd0, rd, 7'h13};
  endfunction
  function automatic logic [31:0] ld(input logic [2:0] f3,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'h03};
  endfunction
  function automatic logic [31:0] st(input logic [2:0] f3,
      input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] add(input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction
  function automatic logic [31:0] beq(input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, 3'd0, off[4:1], off[11], 7'h63};
  endfunction
  function automatic logic [31:0] jal(input logic [4:0] rd,
      input logic [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
  endfunction

  task automatic hold(input logic [31:0] fill);
    @(negedge clk);
    boot_add = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
    for (int i = 0; i < 64; i++) dmem[i] = fill;
  endtask

  task automatic release_rst();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_wr();
    int n;
    n = 0;
    while (WR !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++; if (WR !== 1'b1) begin errors++; $display("FAIL wr_timeout got WR=%b exp 1", WR); end
  endtask

  task automatic test_reset();
    hold(32'h0);
    #1;
    checks++; if (A_IMEM !== 32'h0) begin errors++; $display("FAIL rst_a_imem got %h exp 0", A_IMEM); end
    checks++; if (RD !== 1'b0 || WR !== 1'b0) begin errors++; $display("FAIL rst_rdwr got %b%b exp 00", RD, WR); end
    checks++; if (byte_mark !== 4'd0) begin errors++; $display("FAIL rst_bm got %b exp 0000", byte_mark); end
    checks++; if (A_DMEM !== 32'h0 || D_out !== 32'h0) begin errors++; $display("FAIL rst_dmem got %h %h exp 0 0", A_DMEM, D_out); end
    checks++; if (DMEM_rst !== 1'b0) begin errors++; $display("FAIL rst_dmem_rst got %b exp 0", DMEM_rst); end
    release_rst();
    for (int k = 0; k < 4; k++) begin
      checks++; if (A_IMEM !== 32'(4 * k)) begin errors++; $display("FAIL seq_fetch%0d got %h exp %h", k, A_IMEM, 32'(4 * k)); end
      @(negedge clk);
    end
    boot_add = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (A_IMEM !== 32'h100) begin errors++; $display("FAIL boot_rst got %h exp 100", A_IMEM); end
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (A_IMEM !== 32'h100) begin errors++; $display("FAIL boot_first got %h exp 100", A_IMEM); end
    @(negedge clk);
    checks++; if (A_IMEM !== 32'h104) begin errors++; $display("FAIL boot_next got %h exp 104", A_IMEM); end
    boot_add = 1'b0;
  endtask

  task automatic test_forward();
    hold(32'h0);
    imem[0] = addi(5'd1, 5'd0, 12'd5);
    imem[1] = addi(5'd2, 5'd1, 12'd3);
    imem[2] = add(5'd3, 5'd1, 5'd2);
    imem[3] = st(3'd2, 5'd3, 5'd0, 12'd0);
    release_rst();
    wait_wr();
    checks++; if (D_out !== 32'd13) begin errors++; $display("FAIL fwd_dout got %h exp d", D_out); end
    checks++; if (byte_mark !== 4'b1111) begin errors++; $display("FAIL fwd_bm got %b exp 1111", byte_mark); end
    checks++; if (A_DMEM !== 32'h0) begin errors++; $display("FAIL fwd_addr got %h exp 0", A_DMEM); end
    repeat (3) @(negedge clk);
    checks++; if (dmem[0] !== 32'd13) begin errors++; $display("FAIL fwd_mem got %h exp d", dmem[0]); end
  endtask

  task automatic test_load_use();
    logic [31:0] exp_pc [7];
    exp_pc = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd16, 32'd20};
    hold(32'h0);
    imem[0] = addi(5'd6, 5'd0, 12'h0A5);
    imem[1] = st(3'd2, 5'd6, 5'd0, 12'h010);
    imem[2] = ld(3'd2, 5'd4, 5'd0, 12'h010);
    imem[3] = addi(5'd5, 5'd4, 12'd1);
    imem[4] = st(3'd2, 5'd5, 5'd0, 12'h014);
    release_rst();
    for (int k = 0; k < 7; k++) begin
      checks++; if (A_IMEM !== exp_pc[k]) begin errors++; $display("FAIL lu_fetch%0d got %h exp %h", k, A_IMEM, exp_pc[k]); end
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    checks++; if (dmem[4] !== 32'hA5) begin errors++; $display("FAIL lu_store got %h exp a5", dmem[4]); end
    checks++; if (dmem[5] !== 32'hA6) begin errors++; $display("FAIL lu_result got %h exp a6", dmem[5]); end
  endtask

  task automatic test_byte_half();
    hold(32'h0);
    imem[0] = addi(5'd7, 5'd0, 12'h080);
    imem[1] = st(3'd0, 5'd7, 5'd0, 12'h021);
    imem[2] = ld(3'd0, 5'd8, 5'd0, 12'h021);
    imem[3] = ld(3'd4, 5'd9, 5'd0, 12'h021);
    imem[4] = st(3'd2, 5'd8, 5'd0, 12'h030);
    imem[5] = st(3'd2, 5'd9, 5'd0, 12'h034);
    release_rst();
    wait_wr();
    checks++; if (byte_mark !== 4'b0010) begin errors++; $display("FAIL sb_bm got %b exp 0010", byte_mark); end
    checks++; if (D_out[15:8] !== 8'h80) begin errors++; $display("FAIL sb_lane got %h exp 80", D_out[15:8]); end
    checks++; if (A_DMEM !== 32'h21) begin errors++; $display("FAIL sb_addr got %h exp 21", A_DMEM); end
    repeat (12) @(negedge clk);
    checks++; if (dmem[8] !== 32'h0000_8000) begin errors++; $display("FAIL sb_mem got %h exp 00008000", dmem[8]); end
    checks++; if (dmem[12] !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_sext got %h exp ffffff80", dmem[12]); end
    checks++; if (dmem[13] !== 32'h0000_0080) begin errors++; $display("FAIL lbu_zext got %h exp 00000080", dmem[13]); end
  endtask

  task automatic test_branch();
    logic [31:0] exp_pc [8];
    int wr_cnt;
    exp_pc = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd24};
    wr_cnt = 0;
    hold(32'hDEAD_BEEF);
    imem[0] = addi(5'd10, 5'd0, 12'd1);
    imem[1] = beq(5'd0, 5'd0, 13'd12);
    imem[2] = addi(5'd11, 5'd0, 12'h055);
    imem[3] = st(3'd2, 5'd10, 5'd0, 12'h040);
    imem[4] = jal(5'd1, 21'd8);
    imem[5] = st(3'd2, 5'd10, 5'd0, 12'h044);
    imem[6] = st(3'd2, 5'd1, 5'd0, 12'h048);
    imem[7] = st(3'd2, 5'd11, 5'd0, 12'h04C);
    release_rst();
    for (int k = 0; k < 20; k++) begin
      if (k < 8) begin
        checks++; if (A_IMEM !== exp_pc[k]) begin errors++; $display("FAIL br_fetch%0d got %h exp %h", k, A_IMEM, exp_pc[k]); end
      end
      if (WR === 1'b1) wr_cnt++;
      @(negedge clk);
    end
    checks++; if (wr_cnt != 2) begin errors++; $display("FAIL br_wr_count got %0d exp 2", wr_cnt); end
    checks++; if (dmem[16] !== 32'hDEAD_BEEF || dmem[17] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL br_flushed_st got %h %h exp deadbeef", dmem[16], dmem[17]); end
    checks++; if (dmem[18] !== 32'd20) begin errors++; $display("FAIL jal_link got %h exp 14", dmem[18]); end
    checks++; if (dmem[19] !== 32'd0) begin errors++; $display("FAIL br_flushed_wb got %h exp 0", dmem[19]); end
  endtask

  task automatic test_x0_async();
    hold(32'hDEAD_BEEF);
    imem[0] = addi(5'd0, 5'd0, 12'd7);
    imem[1] = st(3'd2, 5'd0, 5'd0, 12'h050);
    imem[2] = addi(5'd12, 5'd0, 12'd3);
    for (int i = 3; i < 60; i++) imem[i] = st(3'd2, 5'd12, 5'd0, 12'h054);
    release_rst();
    repeat (12) @(negedge clk);
    checks++; if (dmem[20] !== 32'd0) begin errors++; $display("FAIL x0_store got %h exp 0", dmem[20]); end
    checks++; if (dmem[21] !== 32'd3) begin errors++; $display("FAIL x12_store got %h exp 3", dmem[21]); end
    checks++; if (WR !== 1'b1) begin errors++; $display("FAIL pre_rst_wr got %b exp 1", WR); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (WR !== 1'b0 || RD !== 1'b0) begin errors++; $display("FAIL async_rdwr got %b%b exp 00", RD, WR); end
    checks++; if (byte_mark !== 4'd0 || D_out !== 32'h0) begin errors++; $display("FAIL async_bus got %b %h exp 0000 0", byte_mark, D_out); end
    checks++; if (A_IMEM !== 32'h0 || A_DMEM !== 32'h0) begin errors++; $display("FAIL async_addr got %h %h exp 0 0", A_IMEM, A_DMEM); end
    dmem[21] = 32'h1234_5678;
    repeat (3) @(negedge clk);
    checks++; if (dmem[21] !== 32'h1234_5678) begin errors++; $display("FAIL async_nowrite got %h exp 12345678", dmem[21]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_byte_half();
    test_branch();
    test_x0_async();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
